peridot_cam_dma: RTL and testbench

Avalon-MM burst write master for the PERIDOT camera capture path. It sits directly downstream of the camera control register block. On each `start` pulse it latches the capture address and cycle count. It then moves pixel data from the show-ahead input FIFO to memory in 64-byte bursts and returns completion on the `done` level that the register block synchronizes and edge-detects.

---
 rtl/peridot_cam_dma_if.sv | 41 ++++
 rtl/peridot_cam_dma.sv | 103 ++++++++++
 tb/tb_peridot_cam_dma.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/peridot_cam_dma_if.sv
// Register-block handshake, show-ahead FIFO read port and Avalon-MM burst write port of peridot_cam_dma.
// master = the DMA engine, slave = the surrounding register block, FIFO and memory.
interface peridot_cam_dma_if #(
  parameter int FIFO_LEVEL_WIDTH = 9
);
  logic                        start;
  logic [31:0]                 capaddress_top;
  logic [15:0]                 capcycle_num;
  logic                        done;

  logic [31:0]                 fifo_q;
  logic [FIFO_LEVEL_WIDTH-1:0] fifo_rdusedw;
  logic                        fifo_rdack;

  logic [31:0]                 avm_m1_address;
  logic                        avm_m1_write;
  logic [31:0]                 avm_m1_writedata;
  logic [3:0]                  avm_m1_byteenable;
  logic [4:0]                  avm_m1_burstcount;
  logic                        avm_m1_waitrequest;

  modport master (
    input  start, capaddress_top, capcycle_num,
    output done,
    input  fifo_q, fifo_rdusedw,
    output fifo_rdack,
    output avm_m1_address, avm_m1_write, avm_m1_writedata,
    output avm_m1_byteenable, avm_m1_burstcount,
    input  avm_m1_waitrequest
  );

  modport slave (
    output start, capaddress_top, capcycle_num,
    input  done,
    output fifo_q, fifo_rdusedw,
    input  fifo_rdack,
    input  avm_m1_address, avm_m1_write, avm_m1_writedata,
    input  avm_m1_byteenable, avm_m1_burstcount,
    output avm_m1_waitrequest
  );
endinterface

// File: rtl/peridot_cam_dma.sv
// Camera capture DMA: on start, writes capcycle_num 16-beat bursts from the show-ahead FIFO; done=1 when idle.
// First write 3 cycles after start; a burst starts only with 16 words buffered and waitrequest freezes the beat.
module peridot_cam_dma #(
  parameter int FIFO_LEVEL_WIDTH = 9
) (
  input  logic              avm_m1_clk,
  input  logic              csi_global_reset_n,
  peridot_cam_dma_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_BURST,
    S_FINISH
  } state_t;

  state_t      state;
  logic [25:0] addr_reg;
  logic [15:0] remain_reg;
  logic [3:0]  beat_cnt;
  logic        done_reg;
  logic        write_reg;

  logic        beat_accept;
  logic        burst_ready;
  logic        addr_lsbs_unused;

  assign beat_accept      = write_reg && !bus.avm_m1_waitrequest;
  assign burst_ready      = bus.fifo_rdusedw >= FIFO_LEVEL_WIDTH'(16);
  assign addr_lsbs_unused = ^bus.capaddress_top[5:0];

  assign bus.done              = done_reg;
  assign bus.fifo_rdack        = beat_accept;
  assign bus.avm_m1_address    = {addr_reg, 6'b0};
  assign bus.avm_m1_write      = write_reg;
  assign bus.avm_m1_writedata  = bus.fifo_q;
  assign bus.avm_m1_byteenable = 4'hF;
  assign bus.avm_m1_burstcount = 5'd16;

  always_ff @(posedge avm_m1_clk or negedge csi_global_reset_n) begin
    if (!csi_global_reset_n) begin
      state      <= S_IDLE;
      addr_reg   <= '0;
      remain_reg <= '0;
      beat_cnt   <= '0;
      done_reg   <= 1'b1;
      write_reg  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            addr_reg   <= bus.capaddress_top[31:6];
            remain_reg <= bus.capcycle_num;
            done_reg   <= 1'b0;
            state      <= S_ARM;
          end
        end

        // Always pass through WAIT, which also handles an empty frame, so done
        // stays low long enough for the register block's synchronizer.
        S_ARM: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (remain_reg == 16'd0) begin
            state <= S_FINISH;
          end else if (burst_ready) begin
            write_reg <= 1'b1;
            beat_cnt  <= 4'd0;
            state     <= S_BURST;
          end
        end

        S_BURST: begin
          if (beat_accept) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (beat_cnt == 4'd15) begin
              write_reg  <= 1'b0;
              addr_reg   <= addr_reg + 26'd1;
              remain_reg <= remain_reg - 16'd1;
              state      <= S_WAIT;
            end
          end
        end

        S_FINISH: begin
          done_reg <= 1'b1;
          state    <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          write_reg <= 1'b0;
          done_reg  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peridot_cam_dma.sv
// Bench for peridot_cam_dma: FIFO/memory model, frame table with expected timing, plus level, restart and reset sequences.
module tb_peridot_cam_dma;

  localparam int LW    = 9;
  localparam int LIMIT = 3000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  peridot_cam_dma_if #(.FIFO_LEVEL_WIDTH(LW)) bus ();

  peridot_cam_dma #(.FIFO_LEVEL_WIDTH(LW)) dut (
    .avm_m1_clk         (clk),
    .csi_global_reset_n (rst_n),
    .bus                (bus.master)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] fifo_m[$];
  logic [31:0] exp_data[$];
  logic [31:0] acc_addr[$];
  logic [31:0] acc_data[$];
  int          rdack_cnt    = 0;
  int          write_cycles = 0;
  bit          pop_pending  = 1'b0;
  bit          stall_en     = 1'b0;
  bit          prev_stall   = 1'b0;
  logic [31:0] prev_addr    = '0;
  logic [31:0] prev_data    = '0;

  typedef struct {
    logic [31:0] addr;
    int          cnt;
    bit          stall;
    bit          inc;
    int          exp_low;
    int          inject;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // FIFO and slave model: pops land just after the accepting edge, level follows
  initial begin
    bus.fifo_q             = '0;
    bus.fifo_rdusedw       = '0;
    bus.avm_m1_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pop_pending) begin
        if (fifo_m.size() > 0) fifo_m.delete(0);
        pop_pending = 1'b0;
      end
      bus.fifo_q             = (fifo_m.size() > 0) ? fifo_m[0] : 32'h0;
      bus.fifo_rdusedw       = LW'(fifo_m.size());
      bus.avm_m1_waitrequest = stall_en && ($urandom_range(0, 1) == 1);
    end
  end

  // Bus monitor: capture accepted beats, check stall stability mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall  = 1'b0;
        pop_pending = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_write_held", 32'(bus.avm_m1_write), 32'd1);
          chk("stall_addr_held", bus.avm_m1_address, prev_addr);
          chk("stall_data_held", bus.avm_m1_writedata, prev_data);
        end
        if (bus.avm_m1_write) write_cycles++;
        if (bus.fifo_rdack) rdack_cnt++;
        if (bus.avm_m1_write && bus.avm_m1_waitrequest)
          chk("rdack_under_stall", 32'(bus.fifo_rdack), 32'd0);
        if (bus.avm_m1_write && !bus.avm_m1_waitrequest) begin
          acc_addr.push_back(bus.avm_m1_address);
          acc_data.push_back(bus.avm_m1_writedata);
          chk("byteenable", 32'(bus.avm_m1_byteenable), 32'hF);
          chk("burstcount", 32'(bus.avm_m1_burstcount), 32'd16);
          pop_pending = 1'b1;
        end
        prev_stall = bus.avm_m1_write && bus.avm_m1_waitrequest;
        prev_addr  = bus.avm_m1_address;
        prev_data  = bus.avm_m1_writedata;
      end
    end
  end

  task automatic preload(input int n, input bit inc);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = inc ? 32'(i) : $urandom;
      fifo_m.push_back(w);
      exp_data.push_back(w);
    end
  endtask

  task automatic clear_capture();
    acc_addr.delete();
    acc_data.delete();
    rdack_cnt    = 0;
    write_cycles = 0;
  endtask

  // Expected beats: burst b goes to the 64-byte-aligned base + 64*b (mod 2^32)
  task automatic check_frame(input logic [31:0] base, input int cnt);
    int          nb;
    logic [31:0] exp_a;
    nb = 16 * cnt;
    chk("beat_count", 32'(acc_addr.size()), 32'(nb));
    chk("rdack_count", 32'(rdack_cnt), 32'(nb));
    for (int i = 0; i < nb && i < acc_addr.size(); i++) begin
      exp_a = {base[31:6], 6'b0} + 32'(i / 16) * 32'd64;
      chk($sformatf("addr[%0d]", i), acc_addr[i], exp_a);
      if (i < exp_data.size())
        chk($sformatf("data[%0d]", i), acc_data[i], exp_data[i]);
    end
    chk("fifo_drained", 32'(fifo_m.size()), 32'd0);
    exp_data.delete();
  endtask

  task automatic run_frame(input vec_t v);
    int low;
    preload(16 * v.cnt, v.inc);
    clear_capture();
    stall_en           = v.stall;
    bus.capaddress_top = v.addr;
    bus.capcycle_num   = 16'(v.cnt);
    bus.start          = 1'b1;
    cyc();
    bus.start          = 1'b0;
    bus.capaddress_top = $urandom;
    bus.capcycle_num   = 16'($urandom_range(1, 9));
    chk("done_fell", 32'(bus.done), 32'd0);
    low = 0;
    while (bus.done === 1'b0 && low < LIMIT) begin
      low++;
      bus.start = (low == v.inject);
      cyc();
    end
    bus.start = 1'b0;
    stall_en  = 1'b0;
    if (low >= LIMIT) chk("done_timeout", 32'(bus.done), 32'd1);
    if (v.exp_low >= 0) chk("done_low_cycles", 32'(low), 32'(v.exp_low));
    if (!v.stall) chk("write_cycles", 32'(write_cycles), 32'(16 * v.cnt));
    check_frame(v.addr, v.cnt);
    repeat (2) cyc();
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int   low;
    vec_t v;

    bus.start          = 1'b0;
    bus.capaddress_top = '0;
    bus.capcycle_num   = '0;
    rst_n              = 1'b0;
    repeat (3) cyc();

    chk("rst_done", 32'(bus.done), 32'd1);
    chk("rst_write", 32'(bus.avm_m1_write), 32'd0);
    chk("rst_rdack", 32'(bus.fifo_rdack), 32'd0);
    chk("rst_address", bus.avm_m1_address, 32'h0);

    rst_n = 1'b1;
    repeat (2) cyc();
    chk("idle_done", 32'(bus.done), 32'd1);
    chk("idle_write", 32'(bus.avm_m1_write), 32'd0);
    chk("idle_byteenable", 32'(bus.avm_m1_byteenable), 32'hF);
    chk("idle_burstcount", 32'(bus.avm_m1_burstcount), 32'd16);

    // done low for 3 + 17 cycles per burst when the FIFO is full and nothing stalls
    tbl[0] = '{addr: 32'h1000_0040, cnt: 2, stall: 1'b0, inc: 1'b1, exp_low: 37, inject: 0};
    tbl[1] = '{addr: 32'h2000_0000, cnt: 0, stall: 1'b0, inc: 1'b0, exp_low: 3,  inject: 0};
    tbl[2] = '{addr: 32'h3000_007F, cnt: 1, stall: 1'b0, inc: 1'b0, exp_low: 20, inject: 0};
    tbl[3] = '{addr: 32'hFFFF_FFC0, cnt: 2, stall: 1'b0, inc: 1'b0, exp_low: 37, inject: 0};
    tbl[4] = '{addr: 32'h4000_0100, cnt: 4, stall: 1'b1, inc: 1'b0, exp_low: -1, inject: 0};
    tbl[5] = '{addr: 32'h5555_5540, cnt: 3, stall: 1'b0, inc: 1'b0, exp_low: 54, inject: 20};
    tbl[6] = '{addr: 32'hABCD_0000, cnt: 4, stall: 1'b1, inc: 1'b0, exp_low: -1, inject: 30};

    for (int i = 0; i < 7; i++) run_frame(tbl[i]);

    // Level stuck at 15: nothing may be issued until the 16th word arrives
    preload(15, 1'b0);
    clear_capture();
    bus.capaddress_top = 32'h6000_0200;
    bus.capcycle_num   = 16'd1;
    bus.start          = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (100) cyc();
    chk("lvl_no_write", 32'(write_cycles), 32'd0);
    chk("lvl_done_low", 32'(bus.done), 32'd0);
    preload(1, 1'b0);
    low = 0;
    while (bus.done === 1'b0 && low < LIMIT) begin
      low++;
      cyc();
    end
    if (low >= LIMIT) chk("lvl_timeout", 32'(bus.done), 32'd1);
    chk("lvl_write_cycles", 32'(write_cycles), 32'd16);
    check_frame(32'h6000_0200, 1);
    repeat (2) cyc();

    // Reset mid-burst: outputs return to reset values without a clock edge
    preload(32, 1'b0);
    clear_capture();
    bus.capaddress_top = 32'h7000_0040;
    bus.capcycle_num   = 16'd2;
    bus.start          = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (8) cyc();
    chk("mid_write_active", 32'(bus.avm_m1_write), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_done", 32'(bus.done), 32'd1);
    chk("arst_write", 32'(bus.avm_m1_write), 32'd0);
    chk("arst_rdack", 32'(bus.fifo_rdack), 32'd0);
    chk("arst_address", bus.avm_m1_address, 32'h0);
    repeat (2) cyc();
    fifo_m.delete();
    exp_data.delete();
    clear_capture();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("post_rst_done", 32'(bus.done), 32'd1);
    chk("post_rst_write", 32'(bus.avm_m1_write), 32'd0);

    v = '{addr: 32'h0800_0FC0, cnt: 1, stall: 1'b0, inc: 1'b1, exp_low: 20, inject: 0};
    run_frame(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
